// File: rtl/pin_harness_pkg.sv
// Shared types, constants and shift helpers for the iCE40 pin stimulus harness.
package pin_harness_pkg;

  localparam int unsigned SIG_W  = 16;
  localparam int unsigned SAMP_W = 4;
  localparam logic [SIG_W-1:0] POLY16 = 16'hB400;

  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, FINAL} state_t;

  // Right-shifting Galois step shared by the pattern LFSR and the MISR
  function automatic logic [SIG_W-1:0] shift16(input logic [SIG_W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY16 : '0);
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SAMP_W-1:0] d);
    return shift16(s) ^ SIG_W'(d);
  endfunction

endpackage

// File: rtl/pin_stimulus_checker_if.sv
// Pin bundle between the harness (master) and the wrapped pack-test DUT (slave).
interface pin_stimulus_checker_if;

  logic cen_pin;
  logic rst_pin;
  logic ina_pin;
  logic inb_pin;
  logic outa_pin;
  logic outb_pin;
  logic outc_pin;
  logic outd_pin;

  modport master (
    output cen_pin, rst_pin, ina_pin, inb_pin,
    input  outa_pin, outb_pin, outc_pin, outd_pin
  );

  modport slave (
    input  cen_pin, rst_pin, ina_pin, inb_pin,
    output outa_pin, outb_pin, outc_pin, outd_pin
  );

endinterface

// File: rtl/misr16.sv
// 16-bit multiple-input signature register compressing a 4-bit sample per enabled cycle.
module misr16
  import pin_harness_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [SAMP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/pin_stimulus_checker.sv
// Drives reset plus an LFSR pattern into the pack-test wrapper and signs its outputs.
module pin_stimulus_checker
  import pin_harness_pkg::*;
#(
  parameter int unsigned      RST_CYCLES = 4,
  parameter int unsigned      NUM_CYCLES = 1024,
  parameter int unsigned      LAT        = 2,
  parameter logic [SIG_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter logic [SIG_W-1:0] EXP_SIG    = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [SIG_W-1:0]       signature,
  pin_stimulus_checker_if.master pins
);

  localparam int unsigned MAX_RN  = (RST_CYCLES > NUM_CYCLES) ? RST_CYCLES : NUM_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_RN > LAT + 1) ? MAX_RN : LAT + 1;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [SIG_W-1:0]   lfsr;
  logic [SIG_W-1:0]   lfsr_nx;
  logic [SAMP_W-1:0]  samp;
  logic               en_q;
  logic               start_c;
  logic               rst_pin_nx;
  logic               run_nx;

  assign start_c = (state == IDLE) && start;

  // Next state: one down-counter reloaded on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lfsr_nx  = lfsr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RESET;
          cnt_nx   = CNT_W'(RST_CYCLES - 1);
          lfsr_nx  = LFSR_SEED;
        end
      end
      RESET: begin
        if (cnt == '0) begin
          state_nx = RUN;
          cnt_nx   = CNT_W'(NUM_CYCLES - 1);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RUN: begin
        lfsr_nx = shift16(lfsr);
        if (cnt == '0) begin
          state_nx = DRAIN;
          cnt_nx   = CNT_W'(LAT);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_nx = FINAL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      FINAL: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pin values are registered from the next state so they line up with the state they belong to
  always_comb begin
    rst_pin_nx = (state_nx == IDLE) || (state_nx == RESET);
    run_nx     = (state_nx == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lfsr         <= LFSR_SEED;
      samp         <= '0;
      en_q         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      pins.rst_pin <= 1'b1;
      pins.cen_pin <= 1'b0;
      pins.ina_pin <= 1'b0;
      pins.inb_pin <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      lfsr         <= lfsr_nx;
      samp         <= {pins.outd_pin, pins.outc_pin, pins.outb_pin, pins.outa_pin};
      en_q         <= (state == RUN) || (state == DRAIN);
      busy         <= (state_nx != IDLE);
      done         <= (state == FINAL);
      pins.rst_pin <= rst_pin_nx;
      pins.ina_pin <= run_nx & lfsr_nx[0];
      pins.inb_pin <= run_nx & lfsr_nx[1];
      pins.cen_pin <= run_nx & (lfsr_nx[2] | lfsr_nx[3]);
      // The last MISR update lands on this same edge, so compare its incoming value
      if (start_c) begin
        pass <= 1'b0;
      end else if (state == FINAL) begin
        pass <= (misr_step(signature, samp) == EXP_SIG);
      end
    end
  end

  misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_c),
    .en  (en_q),
    .din (samp),
    .sig (signature)
  );

endmodule

// File: tb/tb_pin_stimulus_checker.sv
// Self-checking bench: three harness configurations plus a standalone misr16 table.
`timescale 1ns/1ps
module tb_pin_stimulus_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_def, start_lb, start_sm;
  logic        busy_def, done_def, pass_def;
  logic        busy_lb, done_lb, pass_lb;
  logic        busy_sm, done_sm, pass_sm;
  logic [15:0] sig_def, sig_lb, sig_sm;
  logic        m_clr, m_en;
  logic [3:0]  m_din;
  logic [15:0] m_sig;

  pin_stimulus_checker_if if_def ();
  pin_stimulus_checker_if if_lb ();
  pin_stimulus_checker_if if_sm ();

  assign if_def.outa_pin = 1'b0;
  assign if_def.outb_pin = 1'b0;
  assign if_def.outc_pin = 1'b0;
  assign if_def.outd_pin = 1'b0;

  assign if_lb.outa_pin = if_lb.ina_pin;
  assign if_lb.outb_pin = if_lb.inb_pin;
  assign if_lb.outc_pin = if_lb.cen_pin;
  assign if_lb.outd_pin = 1'b0;

  assign if_sm.outa_pin = 1'b1;
  assign if_sm.outb_pin = 1'b0;
  assign if_sm.outc_pin = 1'b1;
  assign if_sm.outd_pin = 1'b1;

  pin_stimulus_checker u_def (
    .clk(clk), .rst(rst), .start(start_def), .busy(busy_def), .done(done_def),
    .pass(pass_def), .signature(sig_def), .pins(if_def)
  );

  pin_stimulus_checker #(.NUM_CYCLES(8), .LAT(0)) u_lb (
    .clk(clk), .rst(rst), .start(start_lb), .busy(busy_lb), .done(done_lb),
    .pass(pass_lb), .signature(sig_lb), .pins(if_lb)
  );

  pin_stimulus_checker #(.RST_CYCLES(1), .NUM_CYCLES(1), .LAT(0)) u_sm (
    .clk(clk), .rst(rst), .start(start_sm), .busy(busy_sm), .done(done_sm),
    .pass(pass_sm), .signature(sig_sm), .pins(if_sm)
  );

  misr16 u_ref (
    .clk(clk), .rst(rst), .clr(m_clr), .en(m_en), .din(m_din), .sig(m_sig)
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  typedef struct {
    int unsigned c;
    logic        rp, a, b, ce, bz;
  } pat_t;

  typedef struct {
    logic        clr, en;
    logic [3:0]  din;
    logic [15:0] exp;
  } mv_t;

  exp_t q_def[$];
  exp_t q_lb[$];
  exp_t q_sm[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  function automatic logic [15:0] b_lfsr(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] b_misr(input logic [15:0] s, input logic [3:0] d);
    return b_lfsr(s) ^ {12'h000, d};
  endfunction

  // Loopback signature: 8 RUN samples {0,cen,inb,ina} then one all-zero DRAIN sample
  function automatic logic [15:0] lb_expect();
    logic [15:0] l;
    logic [15:0] s;
    l = 16'hACE1;
    s = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      s = b_misr(s, {1'b0, l[2] | l[3], l[1], l[0]});
      l = b_lfsr(l);
    end
    s = b_misr(s, 4'h0);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_extra(input string name);
    checks++;
    failures++;
    $display("FAIL %s: done pulse with no pending run (got 1 expected 0, cycle %0d)", name, cyc);
  endtask

  task automatic chk_done(input string nm, input logic [15:0] s, input logic p, input exp_t e);
    chk({nm, "_done_cycle"}, cyc, e.cyc);
    chk({nm, "_signature"}, 32'(s), 32'(e.sig));
    chk({nm, "_pass"}, 32'(p), 32'(e.pass));
  endtask

  // Advance one cycle, then pop the scoreboard for every done pulse seen
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (done_def) begin
      if (q_def.size() == 0) fail_extra("def_unexpected_done");
      else begin e = q_def.pop_front(); chk_done("def", sig_def, pass_def, e); end
    end
    if (done_lb) begin
      if (q_lb.size() == 0) fail_extra("lb_unexpected_done");
      else begin e = q_lb.pop_front(); chk_done("lb", sig_lb, pass_lb, e); end
    end
    if (done_sm) begin
      if (q_sm.size() == 0) fail_extra("sm_unexpected_done");
      else begin e = q_sm.pop_front(); chk_done("sm", sig_sm, pass_sm, e); end
    end
  endtask

  task automatic go(input int which, input logic [15:0] s, input logic p, input int unsigned lat);
    exp_t e;
    e.cyc  = cyc + 1 + lat;
    e.sig  = s;
    e.pass = p;
    case (which)
      0: begin q_def.push_back(e); start_def = 1'b1; end
      1: begin q_lb.push_back(e);  start_lb  = 1'b1; end
      default: begin q_sm.push_back(e); start_sm = 1'b1; end
    endcase
    tick();
    start_def = 1'b0;
    start_lb  = 1'b0;
    start_sm  = 1'b0;
  endtask

  initial begin
    pat_t        pt[8];
    mv_t         mt[8];
    logic [15:0] l;
    logic [15:0] s;
    logic [15:0] lbx;
    int          pi;
    int          pm;
    exp_t        e;

    pt[0] = '{0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pt[1] = '{3,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pt[2] = '{4,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pt[3] = '{5,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pt[4] = '{6,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pt[5] = '{1028, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pt[6] = '{1031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pt[7] = '{1032, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    mt[0] = '{1'b1, 1'b0, 4'h0, 16'h0};
    mt[1] = '{1'b0, 1'b1, 4'h5, 16'h0};
    mt[2] = '{1'b0, 1'b1, 4'hA, 16'h0};
    mt[3] = '{1'b0, 1'b0, 4'hF, 16'h0};
    mt[4] = '{1'b0, 1'b1, 4'hF, 16'h0};
    mt[5] = '{1'b0, 1'b1, 4'h3, 16'h0};
    mt[6] = '{1'b1, 1'b1, 4'h7, 16'h0};
    mt[7] = '{1'b0, 1'b1, 4'h0, 16'h0};
    s = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (mt[i].clr) s = 16'h0000;
      else if (mt[i].en) s = b_misr(s, mt[i].din);
      mt[i].exp = s;
    end

    lbx = lb_expect();

    rst = 1'b1;
    start_def = 1'b0; start_lb = 1'b0; start_sm = 1'b0;
    m_clr = 1'b0; m_en = 1'b0; m_din = 4'h0;
    tick();
    tick();
    chk("rst_busy", 32'(busy_def), 32'd0);
    chk("rst_done", 32'(done_def), 32'd0);
    chk("rst_pass", 32'(pass_def), 32'd0);
    chk("rst_signature", 32'(sig_def), 32'd0);
    chk("rst_rst_pin", 32'(if_def.rst_pin), 32'd1);
    chk("rst_cen_pin", 32'(if_def.cen_pin), 32'd0);
    chk("rst_ina_pin", 32'(if_def.ina_pin), 32'd0);
    chk("rst_inb_pin", 32'(if_def.inb_pin), 32'd0);
    rst = 1'b0;
    tick();

    // Default configuration, outputs tied low: full run with pattern check
    go(0, 16'h0000, 1'b1, 1032);
    l  = 16'hACE1;
    pi = 0;
    pm = 0;
    for (int c = 0; c < 1040; c++) begin
      if (pi < 8 && pt[pi].c == c) begin
        chk($sformatf("def_rst_pin_c%0d", c), 32'(if_def.rst_pin), 32'(pt[pi].rp));
        chk($sformatf("def_ina_c%0d", c), 32'(if_def.ina_pin), 32'(pt[pi].a));
        chk($sformatf("def_inb_c%0d", c), 32'(if_def.inb_pin), 32'(pt[pi].b));
        chk($sformatf("def_cen_c%0d", c), 32'(if_def.cen_pin), 32'(pt[pi].ce));
        chk($sformatf("def_busy_c%0d", c), 32'(busy_def), 32'(pt[pi].bz));
        pi++;
      end
      if (c >= 4 && c < 1028) begin
        if ({if_def.ina_pin, if_def.inb_pin, if_def.cen_pin} !== {l[0], l[1], l[2] | l[3]}) pm++;
        l = b_lfsr(l);
      end
      tick();
    end
    chk("def_pattern_mismatches", 32'(pm), 32'd0);
    chk("def_pending_runs", 32'(q_def.size()), 32'd0);

    // Loopback with start pulses in RUN (c=6) and FINAL (c=13) that must be ignored
    go(1, lbx, (lbx == 16'h0000), 14);
    for (int c = 0; c < 20; c++) begin
      start_lb = (c == 6) || (c == 13);
      tick();
    end
    start_lb = 1'b0;
    chk("lb_pending_runs", 32'(q_lb.size()), 32'd0);
    chk("lb_held_signature", 32'(sig_lb), 32'(lbx));

    // Restart reloads the seed: same first pattern and same signature
    go(1, lbx, (lbx == 16'h0000), 14);
    for (int c = 0; c < 20; c++) begin
      if (c == 4) begin
        chk("lb_restart_ina", 32'(if_lb.ina_pin), 32'd1);
        chk("lb_restart_inb", 32'(if_lb.inb_pin), 32'd0);
        chk("lb_restart_cen", 32'(if_lb.cen_pin), 32'd0);
      end
      tick();
    end
    chk("lb_restart_pending", 32'(q_lb.size()), 32'd0);

    // Minimal configuration, start held high across done: back-to-back runs
    e.sig = 16'hB40B;
    e.pass = 1'b0;
    e.cyc = cyc + 1 + 4;
    q_sm.push_back(e);
    e.cyc = cyc + 1 + 9;
    q_sm.push_back(e);
    start_sm = 1'b1;
    for (int c = -1; c < 14; c++) begin
      if (c == 0) chk("sm_busy_c0", 32'(busy_sm), 32'd1);
      if (c == 5) start_sm = 1'b0;
      tick();
    end
    start_sm = 1'b0;
    chk("sm_pending_runs", 32'(q_sm.size()), 32'd0);

    // Synchronous reset in the middle of RUN on two instances
    go(0, 16'h0000, 1'b1, 1032);
    go(1, lbx, (lbx == 16'h0000), 14);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rst_pin", 32'(if_lb.rst_pin), 32'd1);
    chk("mid_rst_cen_pin", 32'(if_lb.cen_pin), 32'd0);
    chk("mid_rst_ina_pin", 32'(if_lb.ina_pin), 32'd0);
    chk("mid_rst_inb_pin", 32'(if_lb.inb_pin), 32'd0);
    chk("mid_rst_busy", 32'(busy_lb), 32'd0);
    chk("mid_rst_signature", 32'(sig_lb), 32'd0);
    chk("mid_rst_def_busy", 32'(busy_def), 32'd0);
    chk("mid_rst_def_rst_pin", 32'(if_def.rst_pin), 32'd1);
    rst = 1'b0;
    q_def.delete();
    q_lb.delete();
    repeat (30) tick();
    chk("post_rst_lb_busy", 32'(busy_lb), 32'd0);

    // misr16 unit vectors
    for (int i = 0; i < 8; i++) begin
      m_clr = mt[i].clr;
      m_en  = mt[i].en;
      m_din = mt[i].din;
      tick();
      chk($sformatf("misr16_vec%0d", i), 32'(m_sig), 32'(mt[i].exp));
    end
    m_clr = 1'b0;
    m_en  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
